prio_drain_mux: RTL

- Parametrised successor to the fixed 32:1 registered select mux used in jet finding.
- Keeps a direct registered-select mode, generalised to N inputs of WIDTH bits.
- Adds a priority-drain mode: a masked snapshot of all inputs is captured, then emitted one item per accepted cycle, lowest index first, with a valid/ready handshake.
- Sits between the per-tower/per-region candidate registers and the serial jet-sort/output stage.

---
 rtl/prio_drain_mux.sv | 126 ++++++++++++
 1 files changed

// File: rtl/prio_drain_mux.sv
// prio_drain_mux: N:1 registered select mux with a priority-drain mode that
// emits a masked snapshot of all inputs, lowest index first, over valid/ready.
//
// state | meaning
// IDLE  | direct select (mode=0) or waiting for start (mode=1)
// DRAIN | emitting snapshot items, one per accepted cycle
module prio_drain_mux #(
    parameter  int WIDTH = 32,
    parameter  int N     = 32,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 start,
    input  logic [SELW-1:0]      sel,
    input  logic [N-1:0]         valid_mask,
    input  logic [N*WIDTH-1:0]   din,
    input  logic                 out_ready,
    output logic                 ready,
    output logic [WIDTH-1:0]     dout,
    output logic [SELW-1:0]      dout_idx,
    output logic                 dout_valid,
    output logic                 done
);

    typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    localparam logic [SELW:0] NLIM = (SELW+1)'(N);

    state_t             state, state_n;
    logic [N-1:0]       rem, rem_n;
    logic [WIDTH-1:0]   snap [N];
    logic [WIDTH-1:0]   din_w [N];
    logic [WIDTH-1:0]   dout_n;
    logic [SELW-1:0]    idx_n;
    logic               vld_n;
    logic               done_n;
    logic               load;
    logic [SELW-1:0]    pidx;
    logic               sel_ok;

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign din_w[k] = din[k*WIDTH +: WIDTH];
    end

    assign ready  = (state == IDLE);
    assign sel_ok = ({1'b0, sel} < NLIM);

    // Descending scan so the lowest set bit is the last (winning) assignment.
    always_comb begin
        pidx = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (rem[i]) pidx = SELW'(i);
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        dout_n  = dout;
        idx_n   = dout_idx;
        vld_n   = dout_valid;
        done_n  = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (!mode) begin
                    idx_n = sel;
                    if (sel_ok) begin
                        dout_n = din_w[sel];
                        vld_n  = valid_mask[sel];
                    end else begin
                        dout_n = '0;
                        vld_n  = 1'b0;
                    end
                end else begin
                    vld_n = 1'b0;
                    if (start) begin
                        load    = 1'b1;
                        rem_n   = valid_mask;
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!dout_valid || out_ready) begin
                    if (rem != '0) begin
                        dout_n      = snap[pidx];
                        idx_n       = pidx;
                        vld_n       = 1'b1;
                        rem_n[pidx] = 1'b0;
                    end else begin
                        vld_n   = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rem        <= '0;
            dout       <= '0;
            dout_idx   <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            for (int k = 0; k < N; k++) snap[k] <= '0;
        end else begin
            state      <= state_n;
            rem        <= rem_n;
            dout       <= dout_n;
            dout_idx   <= idx_n;
            dout_valid <= vld_n;
            done       <= done_n;
            if (load) begin
                for (int k = 0; k < N; k++) snap[k] <= din_w[k];
            end
        end
    end

endmodule
